mem_stage_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register in the 64-bit pipeline.
- Decodes the M control bits, resolves the branch, and runs a req/ack handshake to data memory.
- Stalls upstream while a memory access is outstanding.
- Drives the MEM/WB bundle (ALU result, load data, WB controls, destination register) to writeback.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_wb_register.sv | 51 +++++
 rtl/mem_stage_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, control-bit indices and FSM encoding for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned RD_W_DEF    = 5;
  localparam int unsigned TIMEOUT_DEF = 16;

  // M control bundle bit positions
  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  // WB control bundle bit positions
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: load-enabled payload plus a one-cycle valid pulse.
module mem_wb_register #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        wb_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        wb_o,
  output logic [RD_W-1:0]   rd_o
);

  logic              valid_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        wb_q;
  logic [RD_W-1:0]   rd_q;

  // Valid follows load every cycle; payload only changes when loaded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        alu_q   <= alu_i;
        rdata_q <= rdata_i;
        wb_q    <= wb_i;
        rd_q    <= rd_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign alu_o   = alu_q;
  assign rdata_o = rdata_q;
  assign wb_o    = wb_q;
  assign rd_o    = rd_q;

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: branch resolve, data-memory req/ack handshake, MEM/WB hand-off.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned RD_W           = RD_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              IValid,
  input  logic [DATA_W-1:0] IAlu,
  input  logic              IZero,
  input  logic [DATA_W-1:0] IAdder,
  input  logic [1:0]        IWB,
  input  logic [2:0]        IM,
  input  logic [DATA_W-1:0] IReadRegister2,
  input  logic [RD_W-1:0]   IInstruction,
  output logic              OStall,
  output logic              OPcSrc,
  output logic [DATA_W-1:0] OBranchTarget,
  output logic              OMemReq,
  output logic              OMemWe,
  output logic [DATA_W-1:0] OMemAddr,
  output logic [DATA_W-1:0] OMemWData,
  input  logic              IMemAck,
  input  logic [DATA_W-1:0] IMemRData,
  output logic              OWbValid,
  output logic [DATA_W-1:0] OAlu,
  output logic [DATA_W-1:0] OReadData,
  output logic [1:0]        OWB,
  output logic [RD_W-1:0]   OInstruction,
  output logic              OErr
);

  state_e            state_q, state_d;
  logic              stall_q, stall_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cap_alu_q, cap_alu_d;
  logic [1:0]        cap_wb_q, cap_wb_d;
  logic [RD_W-1:0]   cap_rd_q, cap_rd_d;

  logic              wb_load_c;
  logic [DATA_W-1:0] wb_alu_c;
  logic [DATA_W-1:0] wb_rdata_c;
  logic [1:0]        wb_wb_c;
  logic [RD_W-1:0]   wb_rd_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // BUSY-cycle counter for the ack timeout
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // State and registered-output flops
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      stall_q   <= 1'b0;
      pcsrc_q   <= 1'b0;
      tgt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      cap_alu_q <= '0;
      cap_wb_q  <= '0;
      cap_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      pcsrc_q   <= pcsrc_d;
      tgt_q     <= tgt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      cap_alu_q <= cap_alu_d;
      cap_wb_q  <= cap_wb_d;
      cap_rd_q  <= cap_rd_d;
    end
  end

  // Next-state and output decode; pulses default low, held values default to hold
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    pcsrc_d    = 1'b0;
    tgt_d      = tgt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    cap_alu_d  = cap_alu_q;
    cap_wb_d   = cap_wb_q;
    cap_rd_d   = cap_rd_q;
    wb_load_c  = 1'b0;
    wb_alu_c   = cap_alu_q;
    wb_rdata_c = '0;
    wb_wb_c    = cap_wb_q;
    wb_rd_c    = cap_rd_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (IValid) begin
          if (IM[M_BRANCH]) begin
            pcsrc_d = IZero;
            tgt_d   = IAdder;
          end
          case ({IM[M_MEMREAD], IM[M_MEMWRITE]})
            2'b00: begin
              wb_load_c = 1'b1;
              wb_alu_c  = IAlu;
              wb_wb_c   = IWB;
              wb_rd_c   = IInstruction;
            end
            2'b11: begin
              err_d     = 1'b1;
              wb_load_c = 1'b1;
              wb_alu_c  = IAlu;
              wb_wb_c   = 2'b00;
              wb_rd_c   = IInstruction;
            end
            default: begin
              req_d     = 1'b1;
              we_d      = IM[M_MEMWRITE];
              addr_d    = IAlu;
              wdata_d   = IReadRegister2;
              stall_d   = 1'b1;
              cap_alu_d = IAlu;
              cap_wb_d  = IWB;
              cap_rd_d  = IInstruction;
              state_d   = BUSY;
`ifdef MEM_TIMEOUT_EN
              cnt_d     = '0;
`endif
            end
          endcase
        end
      end

      BUSY: begin
        if (IMemAck) begin
          req_d     = 1'b0;
          stall_d   = 1'b0;
          state_d   = IDLE;
          wb_load_c = 1'b1;
          if (we_q) begin
            wb_wb_c[WB_REGWRITE] = 1'b0;
            wb_wb_c[WB_MEMTOREG] = cap_wb_q[WB_MEMTOREG];
          end else begin
            wb_rdata_c = IMemRData;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d     = 1'b0;
          stall_d   = 1'b0;
          state_d   = IDLE;
          err_d     = 1'b1;
          wb_load_c = 1'b1;
          wb_wb_c   = 2'b00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  mem_wb_register #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_mem_wb (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .load_i  (wb_load_c),
    .alu_i   (wb_alu_c),
    .rdata_i (wb_rdata_c),
    .wb_i    (wb_wb_c),
    .rd_i    (wb_rd_c),
    .valid_o (OWbValid),
    .alu_o   (OAlu),
    .rdata_o (OReadData),
    .wb_o    (OWB),
    .rd_o    (OInstruction)
  );

  assign OStall        = stall_q;
  assign OPcSrc        = pcsrc_q;
  assign OBranchTarget = tgt_q;
  assign OMemReq       = req_q;
  assign OMemWe        = we_q;
  assign OMemAddr      = addr_q;
  assign OMemWData     = wdata_q;
  assign OErr          = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit; timeout case runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_unit;

  logic        Clk;
  logic        Rst_n;
  logic        IValid;
  logic [63:0] IAlu;
  logic        IZero;
  logic [63:0] IAdder;
  logic [1:0]  IWB;
  logic [2:0]  IM;
  logic [63:0] IReadRegister2;
  logic [4:0]  IInstruction;
  logic        OStall;
  logic        OPcSrc;
  logic [63:0] OBranchTarget;
  logic        OMemReq;
  logic        OMemWe;
  logic [63:0] OMemAddr;
  logic [63:0] OMemWData;
  logic        IMemAck;
  logic [63:0] IMemRData;
  logic        OWbValid;
  logic [63:0] OAlu;
  logic [63:0] OReadData;
  logic [1:0]  OWB;
  logic [4:0]  OInstruction;
  logic        OErr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_unit #(
    .DATA_W         (64),
    .RD_W           (5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .IValid         (IValid),
    .IAlu           (IAlu),
    .IZero          (IZero),
    .IAdder         (IAdder),
    .IWB            (IWB),
    .IM             (IM),
    .IReadRegister2 (IReadRegister2),
    .IInstruction   (IInstruction),
    .OStall         (OStall),
    .OPcSrc         (OPcSrc),
    .OBranchTarget  (OBranchTarget),
    .OMemReq        (OMemReq),
    .OMemWe         (OMemWe),
    .OMemAddr       (OMemAddr),
    .OMemWData      (OMemWData),
    .IMemAck        (IMemAck),
    .IMemRData      (IMemRData),
    .OWbValid       (OWbValid),
    .OAlu           (OAlu),
    .OReadData      (OReadData),
    .OWB            (OWB),
    .OInstruction   (OInstruction),
    .OErr           (OErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    IValid = 1'b0; IM = 3'b000; IWB = 2'b00; IZero = 1'b0;
    IAlu = 64'd0; IAdder = 64'd0; IReadRegister2 = 64'd0; IInstruction = 5'd0;
    IMemAck = 1'b0; IMemRData = 64'd0;
  endtask

  initial begin
    idle_inputs();
    Rst_n = 1'b0;
    #2;
    check("rst_req",   64'(OMemReq),  64'd0);
    check("rst_stall", 64'(OStall),   64'd0);
    check("rst_wbv",   64'(OWbValid), 64'd0);
    check("rst_alu",   OAlu,          64'd0);
    #10 Rst_n = 1'b1;
    step();

    // R-type bundle
    IValid = 1'b1; IM = 3'b000; IWB = 2'b10; IAlu = 64'h2A; IInstruction = 5'd5;
    step();
    idle_inputs();
    check("r_wbv",   64'(OWbValid),     64'd1);
    check("r_alu",   OAlu,              64'h2A);
    check("r_wb",    64'(OWB),          64'd2);
    check("r_rd",    64'(OInstruction), 64'd5);
    check("r_req",   64'(OMemReq),      64'd0);
    check("r_stall", 64'(OStall),       64'd0);
    check("r_rdata", OReadData,         64'd0);
    step();
    check("r_wbv_pulse", 64'(OWbValid), 64'd0);

    // Load, ack on the 4th edge after issue (req high for 3 sampled cycles)
    IValid = 1'b1; IM = 3'b010; IWB = 2'b11; IAlu = 64'h100; IInstruction = 5'd9;
    step();
    // upstream is frozen; a branch bundle presented while BUSY must be ignored
    IM = 3'b100; IZero = 1'b1; IAdder = 64'h999; IAlu = 64'h777;
    for (int i = 0; i < 3; i++) begin
      check("ld_req",   64'(OMemReq),  64'd1);
      check("ld_stall", 64'(OStall),   64'd1);
      check("ld_addr",  OMemAddr,      64'h100);
      check("ld_we",    64'(OMemWe),   64'd0);
      check("ld_wbv",   64'(OWbValid), 64'd0);
      check("ld_pcsrc", 64'(OPcSrc),   64'd0);
      if (i == 2) begin
        idle_inputs();
        IMemAck = 1'b1; IMemRData = 64'hDEADBEEF;
      end
      step();
    end
    idle_inputs();
    check("ld_done_wbv",   64'(OWbValid),     64'd1);
    check("ld_done_rdata", OReadData,         64'hDEADBEEF);
    check("ld_done_rd",    64'(OInstruction), 64'd9);
    check("ld_done_alu",   OAlu,              64'h100);
    check("ld_done_wb",    64'(OWB),          64'd3);
    check("ld_done_req",   64'(OMemReq),      64'd0);
    check("ld_done_stall", 64'(OStall),       64'd0);
    step();
    check("ld_wbv_pulse", 64'(OWbValid), 64'd0);

    // Store with immediate ack
    IValid = 1'b1; IM = 3'b001; IWB = 2'b10; IAlu = 64'h200;
    IReadRegister2 = 64'h55; IInstruction = 5'd3;
    step();
    idle_inputs();
    check("st_req",   64'(OMemReq), 64'd1);
    check("st_we",    64'(OMemWe),  64'd1);
    check("st_wdata", OMemWData,    64'h55);
    check("st_addr",  OMemAddr,     64'h200);
    IMemAck = 1'b1; IMemRData = 64'h1234;
    step();
    check("st_done_wbv",   64'(OWbValid), 64'd1);
    check("st_done_wb",    64'(OWB),      64'd0);
    check("st_done_rdata", OReadData,     64'd0);
    check("st_done_req",   64'(OMemReq),  64'd0);
    // ack held high while IDLE: ignored, no error
    step();
    idle_inputs();
    check("idle_ack_err", 64'(OErr),     64'd0);
    check("idle_ack_wbv", 64'(OWbValid), 64'd0);
    check("idle_ack_req", 64'(OMemReq),  64'd0);

    // Branch taken, then not taken
    IValid = 1'b1; IM = 3'b100; IZero = 1'b1; IAdder = 64'h40;
    step();
    idle_inputs();
    check("br_pcsrc", 64'(OPcSrc),   64'd1);
    check("br_tgt",   OBranchTarget, 64'h40);
    step();
    check("br_pulse", 64'(OPcSrc), 64'd0);
    IValid = 1'b1; IM = 3'b100; IZero = 1'b0; IAdder = 64'h80;
    step();
    idle_inputs();
    check("brn_pcsrc", 64'(OPcSrc),   64'd0);
    check("brn_tgt",   OBranchTarget, 64'h80);

    // Illegal M = 011
    IValid = 1'b1; IM = 3'b011; IWB = 2'b11; IAlu = 64'h33; IInstruction = 5'd7;
    step();
    idle_inputs();
    check("ill_err",   64'(OErr),     64'd1);
    check("ill_req",   64'(OMemReq),  64'd0);
    check("ill_stall", 64'(OStall),   64'd0);
    check("ill_wbv",   64'(OWbValid), 64'd1);
    check("ill_wb",    64'(OWB),      64'd0);
    step();
    check("ill_err_pulse", 64'(OErr), 64'd0);
    check("ill_req_after", 64'(OMemReq), 64'd0);

    // Async reset in the middle of BUSY
    IValid = 1'b1; IM = 3'b010; IAlu = 64'h300; IInstruction = 5'd4;
    step();
    idle_inputs();
    check("ar_req_pre", 64'(OMemReq), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("ar_req",   64'(OMemReq), 64'd0);
    check("ar_stall", 64'(OStall),  64'd0);
    check("ar_addr",  OMemAddr,     64'd0);
    #3 Rst_n = 1'b1;
    // back in IDLE: an R-type completes in one cycle
    IValid = 1'b1; IM = 3'b000; IWB = 2'b10; IAlu = 64'h11; IInstruction = 5'd2;
    step();
    idle_inputs();
    check("ar_idle_wbv", 64'(OWbValid), 64'd1);
    check("ar_idle_alu", OAlu,          64'h11);
    check("ar_idle_req", 64'(OMemReq),  64'd0);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: times out after 4 BUSY edges
    step();
    IValid = 1'b1; IM = 3'b010; IWB = 2'b11; IAlu = 64'h500; IInstruction = 5'd6;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait_req", 64'(OMemReq), 64'd1);
      check("to_wait_err", 64'(OErr),    64'd0);
    end
    step();
    check("to_err",   64'(OErr),     64'd1);
    check("to_wbv",   64'(OWbValid), 64'd1);
    check("to_wb",    64'(OWB),      64'd0);
    check("to_rdata", OReadData,     64'd0);
    check("to_req",   64'(OMemReq),  64'd0);
    check("to_stall", 64'(OStall),   64'd0);
    IValid = 1'b1; IM = 3'b000; IWB = 2'b10; IAlu = 64'h66; IInstruction = 5'd1;
    step();
    idle_inputs();
    check("to_idle_wbv", 64'(OWbValid), 64'd1);
    check("to_idle_alu", OAlu,          64'h66);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
